// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   Load/store initiator between the MEM stage of the multicycle datapath and
//   the byte-enabled data memory. It takes one op per request, drives the
//   memory word address, byte enables, write data and write enable for a
//   single cycle, and extends and registers load results. Misaligned or
//   out-of-range accesses are reported with fault and never touch memory.
//
//   State table:
//     state   | meaning
//     S_IDLE  | waiting for req; op/vaddr/wdata latched on acceptance
//     S_ISSUE | memory port driven; store written / load captured at exit edge
//     S_DONE  | done (and fault on error) pulse; returns to S_IDLE
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     req, op, vaddr     request, op code (lw,lh,lhu,lb,lbu,sw,sh,sb), byte address
//     wdata              store data, low-aligned
//     busy, done, fault  status: in flight, completion pulse, error pulse
//     rdata              extended load result
//     dm_addr, dm_be     word address and byte enables to memory
//     dm_din, dm_we      write data (unshifted) and write enable to memory
//     dm_dout            combinational read data from memory
module dm_access_ctrl #(
   parameter int ADDR_HI     = 12,
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [2:0]        op,
   input  logic [31:0]       vaddr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              fault,
   output logic [31:0]       rdata,
   output logic [ADDR_HI-2:0] dm_addr,
   output logic [3:0]        dm_be,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   input  logic [31:0]       dm_dout
);

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LHU = 3'b010;
   localparam logic [2:0] OP_LB  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_SW  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        is_store, is_word, is_half;
   logic        misalign, out_of_range, error;
   logic [3:0]  be_dec;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;

   always_comb begin
      is_store = (op_q >= OP_SW);
      is_word  = (op_q == OP_LW) || (op_q == OP_SW);
      is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
      misalign = is_word ? (addr_q[1:0] != 2'b00) :
                 is_half ? addr_q[0] : 1'b0;
      // Shift form keeps this legal even when ADDR_HI leaves no upper bits.
      out_of_range = CHECK_RANGE && ((addr_q >> (ADDR_HI + 1)) != 32'd0);
      error = misalign | out_of_range;

      be_dec = 4'b0001 << addr_q[1:0];
      if (is_word)
         be_dec = 4'b1111;
      else if (is_half)
         be_dec = addr_q[1] ? 4'b1100 : 4'b0011;

      ld_byte = 8'h00;
      case (addr_q[1:0])
         2'd0: ld_byte = dm_dout[7:0];
         2'd1: ld_byte = dm_dout[15:8];
         2'd2: ld_byte = dm_dout[23:16];
         default: ld_byte = dm_dout[31:24];
      endcase
      ld_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];

      load_val = dm_dout;
      case (op_q)
         OP_LH:  load_val = {{16{ld_half[15]}}, ld_half};
         OP_LHU: load_val = {16'h0000, ld_half};
         OP_LB:  load_val = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: load_val = {24'h000000, ld_byte};
         default: load_val = dm_dout;
      endcase
   end

   // Port controls decode straight from state so reset kills a pending write at once.
   assign dm_we   = (state == S_ISSUE) && is_store && !error;
   assign dm_be   = ((state == S_ISSUE) && !error) ? be_dec : 4'b0000;
   assign dm_addr = addr_q[ADDR_HI:2];
   assign dm_din  = wdata_q;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         op_q    <= 3'b000;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata   <= 32'd0;
         done    <= 1'b0;
         fault   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done  <= 1'b0;
               fault <= 1'b0;
               if (req) begin
                  op_q    <= op;
                  addr_q  <= vaddr;
                  wdata_q <= wdata;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!error && !is_store)
                  rdata <= load_val;
               done  <= 1'b1;
               fault <= error;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               fault <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               fault <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl
//   Bench for dm_access_ctrl: a behavioural byte-addressed memory model and a
//   byte-level reference of the load/store rules, with directed and random ops.
module tb_dm_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [2:0]  op;
   logic [31:0] vaddr, wdata;
   logic        busy, done, fault;
   logic [31:0] rdata;
   logic [10:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_din;
   logic        dm_we;
   logic [31:0] dm_dout;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:2047];
   logic [7:0]  ref_mem [0:8191];
   logic [31:0] ref_rdata;
   logic        clr_mem;

   dm_access_ctrl #(.ADDR_HI(12), .CHECK_RANGE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .vaddr(vaddr), .wdata(wdata),
      .busy(busy), .done(done), .fault(fault), .rdata(rdata),
      .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
   );

   always #5 clk = ~clk;

   // Memory places the low-aligned write data into the enabled lanes.
   function automatic logic [31:0] mem_write(logic [31:0] old, logic [31:0] din, logic [3:0] be);
      int lo = 0;
      logic [31:0] r = old;
      for (int k = 3; k >= 0; k--) if (be[k]) lo = k;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = din[8*(k-lo) +: 8];
      return r;
   endfunction

   assign dm_dout = mem[dm_addr];

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 32'd0;
      end else if (dm_we) begin
         mem[dm_addr] <= mem_write(mem[dm_addr], dm_din, dm_be);
      end
   end

   function automatic int op_size(logic [2:0] o);
      if (o == 3'd0 || o == 3'd5) return 4;
      if (o == 3'd1 || o == 3'd2 || o == 3'd6) return 2;
      return 1;
   endfunction

   function automatic bit op_err(logic [2:0] o, logic [31:0] a);
      return (a > 32'h1FFF) || ((a % op_size(o)) != 0);
   endfunction

   function automatic logic [31:0] ref_load(logic [2:0] o, logic [31:0] a);
      int sz = op_size(o);
      longint v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(ref_mem[a + i]) << (8*i));
      if ((o == 3'd1 || o == 3'd3) && v >= (longint'(1) << (8*sz - 1)))
         v = v - (longint'(1) << (8*sz));
      return 32'(v);
   endfunction

   // Entered and left at a negedge with the DUT idle.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, input string tag);
      bit err = op_err(o, a);
      bit st = (o >= 3'd5);
      int sz = op_size(o);
      logic [3:0] exp_be = err ? 4'b0000 : 4'(((1 << sz) - 1) << (a % 4));
      req = 1'b1; op = o; vaddr = a; wdata = w;
      @(negedge clk);
      req = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s issue busy got %b want 1", tag, busy); end
      checks++; if (dm_we !== (st && !err)) begin errors++; $display("FAIL %s issue dm_we got %b want %b", tag, dm_we, st && !err); end
      checks++; if (dm_be !== exp_be) begin errors++; $display("FAIL %s issue dm_be got %b want %b", tag, dm_be, exp_be); end
      checks++; if (dm_addr !== a[12:2]) begin errors++; $display("FAIL %s issue dm_addr got %h want %h", tag, dm_addr, a[12:2]); end
      if (st) begin
         checks++; if (dm_din !== w) begin errors++; $display("FAIL %s issue dm_din got %h want %h", tag, dm_din, w); end
      end
      if (!err) begin
         if (st) for (int i = 0; i < sz; i++) ref_mem[a + i] = w[8*i +: 8];
         else ref_rdata = ref_load(o, a);
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done got %b want 1", tag, done); end
      checks++; if (fault !== err) begin errors++; $display("FAIL %s fault got %b want %b", tag, fault, err); end
      checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL %s rdata got %h want %h", tag, rdata, ref_rdata); end
      checks++; if (dm_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL %s done-cycle we/busy got %b/%b want 0/1", tag, dm_we, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after done/busy got %b/%b want 0/0", tag, done, busy); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 1'b0; op = 3'd0; vaddr = 32'd0; wdata = 32'd0; clr_mem = 1'b1;
      for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
      ref_rdata = 32'd0;
      repeat (3) @(negedge clk);
      clr_mem = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset status got %b%b%b want 000", busy, done, fault); end
      checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset rdata got %h want 0", rdata); end
      checks++; if (dm_we !== 1'b0 || dm_be !== 4'b0000) begin errors++; $display("FAIL reset we/be got %b/%b want 0/0000", dm_we, dm_be); end
      checks++; if (dm_addr !== 11'd0 || dm_din !== 32'd0) begin errors++; $display("FAIL reset addr/din got %h/%h want 0/0", dm_addr, dm_din); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [2:0]  lop [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
      logic [31:0] lad [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
      logic [31:0] lex [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFAAAD, 32'h0000AAAD, 32'hAAADBEEF};
      do_op(3'd5, 32'h10, 32'hDEADBEEF, "sw_dir");
      checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dir word4 got %h want DEADBEEF", mem[4]); end
      do_op(3'd7, 32'h13, 32'h000000AA, "sb_dir");
      checks++; if (mem[4] !== 32'hAAADBEEF) begin errors++; $display("FAIL sb_dir word4 got %h want AAADBEEF", mem[4]); end
      for (int i = 0; i < 5; i++) begin
         do_op(lop[i], lad[i], 32'h0, "ld_dir");
         checks++; if (rdata !== lex[i]) begin errors++; $display("FAIL ld_dir%0d rdata got %h want %h", i, rdata, lex[i]); end
      end
      do_op(3'd6, 32'h10, 32'h00001234, "sh_dir");
      checks++; if (mem[4] !== 32'hAAAD1234) begin errors++; $display("FAIL sh_dir word4 got %h want AAAD1234", mem[4]); end
   endtask

   task automatic test_faults();
      logic [31:0] keep = rdata;
      do_op(3'd0, 32'h11, 32'h0, "lw_mis");
      do_op(3'd6, 32'h13, 32'hBBBB, "sh_mis");
      do_op(3'd5, 32'h2000, 32'h12345678, "sw_rng");
      checks++; if (rdata !== keep) begin errors++; $display("FAIL faults rdata got %h want %h", rdata, keep); end
      checks++; if (mem[4] !== 32'hAAAD1234 || mem[0] !== 32'd0) begin errors++; $display("FAIL faults mem got %h/%h want AAAD1234/0", mem[4], mem[0]); end
   endtask

   task automatic test_back_to_back();
      req = 1'b1; op = 3'd0; vaddr = 32'h10; wdata = 32'd0;
      ref_rdata = ref_load(3'd0, 32'h10);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         checks++; if (done !== (i % 3 == 2)) begin errors++; $display("FAIL b2b cycle %0d done got %b want %b", i, done, (i % 3 == 2)); end
      end
      req = 1'b0;
      checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL b2b rdata got %h want %h", rdata, ref_rdata); end
      @(negedge clk);
   endtask

   task automatic test_req_ignored();
      req = 1'b1; op = 3'd4; vaddr = 32'h10; wdata = 32'd0;
      ref_rdata = ref_load(3'd4, 32'h10);
      @(negedge clk);
      op = 3'd5; vaddr = 32'h20; wdata = 32'h55555555;
      @(negedge clk);
      checks++; if (done !== 1'b1 || rdata !== ref_rdata) begin errors++; $display("FAIL ignore first op done/rdata got %b/%h want 1/%h", done, rdata, ref_rdata); end
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0 || dm_we !== 1'b0) begin errors++; $display("FAIL ignore cycle %0d busy/we got %b/%b want 0/0", i, busy, dm_we); end
      end
      checks++; if (mem[8] !== 32'd0) begin errors++; $display("FAIL ignore word8 got %h want 0", mem[8]); end
   endtask

   task automatic test_reset_mid();
      req = 1'b1; op = 3'd5; vaddr = 32'h40; wdata = 32'h12345678;
      @(negedge clk);
      req = 1'b0;
      checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL rstmid pre we got %b want 1", dm_we); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dm_we !== 1'b0 || busy !== 1'b0 || dm_be !== 4'b0000) begin errors++; $display("FAIL rstmid we/busy/be got %b/%b/%b want 0/0/0000", dm_we, busy, dm_be); end
      ref_rdata = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid cycle %0d done/busy got %b/%b want 0/0", i, done, busy); end
      end
      checks++; if (mem[16] !== 32'd0 || rdata !== 32'd0) begin errors++; $display("FAIL rstmid word16/rdata got %h/%h want 0/0", mem[16], rdata); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         logic [2:0]  o = 3'($urandom_range(0, 7));
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) a = $urandom | 32'h2000;
         else a = $urandom_range(0, 32'h1FFF);
         if ($urandom_range(0, 1) == 1) a = a & ~(32'(op_size(o)) - 1);
         do_op(o, a, $urandom, "rand");
      end
   endtask

   task automatic test_mem_image();
      int bad = 0;
      for (int w = 0; w < 2048; w++)
         if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL mem_image words differing got %0d want 0", bad); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_faults();
      test_back_to_back();
      test_req_ignored();
      test_reset_mid();
      test_random();
      test_mem_image();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
